uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter; serialises one byte per frame onto txd: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//  Pairs with the existing uart_rx receiver on the same clk domain. Loopback and FIFO test designs drive it from a FIFO read port.
//  Uses a valid/ready handshake on the byte input and a one-cycle done pulse at frame end.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock frequency, Hz
//  UART_BAUD    115200      line baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BAUD (integer divide, 434 at defaults)
//  PARITY_MODE  0           0 = none, 1 = odd, 2 = even; 3 is illegal (elaboration error)
//  STOP_BITS    1           1 or 2; any other value is illegal
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  synchronous reset, active-high
//  tx_valid      in   1  tx_data is presented for transmission
//  tx_data       in   8  byte to send; sampled only on the accept cycle
//  tx_ready      out  1  block is idle and accepts a byte this cycle
//  uart_tx_done  out  1  one-cycle pulse when the last stop bit completes
//  uart_txd      out  1  serial line, idle high, registered output
// BEHAVIOUR
//  Reset values: uart_txd=1, tx_ready=1, uart_tx_done=0, FSM=IDLE, counters=0, shift reg=0.
//  Accept: tx_valid & tx_ready on edge N -> byte latched, FSM->START, tx_ready=0 from N+1; uart_txd=0 from N+1.
//  FSM: IDLE -> START -> DATA(x8) -> PARITY (only if PARITY_MODE!=0) -> STOP(xSTOP_BITS) -> IDLE.
//  Every bit, including each stop bit, holds uart_txd for exactly BAUD_CNT_MAX cycles.
//  baud_cnt: 16 bit, runs 0..BAUD_CNT_MAX-1 outside IDLE, held at 0 in IDLE. Bit advances when baud_cnt==BAUD_CNT_MAX-1.
//  bit_cnt: 3 bit, indexes data bits 0..7; reused to count stop bits.
//  Parity bit: odd = ~^data, even = ^data, computed from the latched byte.
//  Frame length = (1+8+P+STOP_BITS)*BAUD_CNT_MAX cycles, where P = (PARITY_MODE!=0). Defaults give 10*434 = 4340 cycles.
//  End of frame: on the last cycle of the final stop bit the FSM goes to IDLE. On the next cycle uart_tx_done=1 and tx_ready=1, both for that cycle.
//  Back-to-back: tx_valid held high is accepted in the first IDLE cycle. Minimum inter-frame gap is exactly 1 cycle of idle-high line.
//  tx_data/tx_valid changes while tx_ready=0 are ignored; the latched byte is not disturbed.
//  tx_valid may drop without a transfer. There is no obligation to hold it, and no buffering of refused bytes.
//  rst mid-frame: next edge uart_txd=1, FSM=IDLE, no done pulse, partial frame abandoned (the receiver sees a framing error).
//  rst has priority over an accept in the same cycle.
//  uart_txd is driven from a flop only; no combinational path from tx_valid to uart_txd.
// STRUCTURE
//  uart_defs.vh (shared with uart_rx): FSM state localparams IDLE/START/DATA/PARITY/STOP (3 bit), PARITY_* codes, BAUD_CNT_MAX formula.
//  One sub-module: uart_baud_gen (counter, en/clear in, bit_tick out). uart_tx instantiates it; uart_rx may adopt it later.
//  Top level holds the FSM, shift register, bit counter, parity and output flops.
// TESTING
//  Simulation uses CLK_FREQ=1_000_000 and UART_BAUD=100_000, giving BAUD_CNT_MAX=10.
//  T1: accept 0x55, no parity, 1 stop -> txd = 0,1,0,1,0,1,0,1,0,1, 10 cycles each; done at cycle 101 after accept; tx_ready low for 100 cycles.
//  T2: PARITY_MODE=2 (even), send 0x07 -> parity bit 1; PARITY_MODE=1 (odd), 0x07 -> 0; frame = 110 cycles.
//  T3: STOP_BITS=2, tx_valid held high with 0xA3 then 0x3C -> two frames of 110 cycles each, exactly 1 idle-high cycle between them, two done pulses.
//  T4: assert rst at cycle 45 of a 0xFF frame -> txd=1 next cycle, tx_ready=1, no done; the next accept of 0x12 produces a clean frame.
//  T5: change tx_data every cycle during a frame -> the serialised byte equals the value sampled at accept.
//  T6: loopback uart_tx -> uart_rx at defaults, 256 bytes 0x00..0xFF -> uart_rx_data matches each byte, one uart_rx_done per byte.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM states, parity codes and baud divisor helper for the UART blocks.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int baud_cnt_max(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; tick_o marks the last cycle of each bit period.
module uart_baud_gen #(
    parameter int CNT_MAX = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = en_i && cnt_q == 16'(CNT_MAX - 1);

    always_comb cnt_d = (clr_i || !en_i || tick_o) ? '0 : cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready UART transmitter with optional parity and 1 or 2 stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UART_BAUD   = 115200,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_tx_done,
    output logic       uart_txd
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BAUD);

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       txd_q, txd_d;
    logic       done_q, done_d;
    logic       tick, accept, par_bit;

    assign accept       = tx_valid && state_q == IDLE;
    assign par_bit      = PARITY_MODE == PARITY_ODD ? ~^data_q : ^data_q;
    assign tx_ready     = state_q == IDLE;
    assign uart_tx_done = done_q;
    assign uart_txd     = txd_q;

    uart_baud_gen #(.CNT_MAX(BAUD_CNT_MAX)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q != IDLE),
        .clr_i (accept),
        .tick_o(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    // bit_cnt wraps to 0 after data bit 7 and is then reused to count stop bits
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE:   if (accept) state_d = START;
            START:  if (tick) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA:   if (tick) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = PARITY_MODE != PARITY_NONE ? PARITY : STOP;
            end
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from the next state so the line changes on the same edge as the FSM
    always_comb begin
        data_d = accept ? tx_data : data_q;
        done_d = state_q == STOP && state_d == IDLE;
        txd_d  = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_q[bit_cnt_d];
            PARITY:  txd_d = par_bit;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random-stimulus scoreboard bench running four parity/stop configurations in parallel.
module tb_uart_tx;

    localparam int BAUD = 10;
    localparam int RUN  = 3000;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp, input int cfg);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s cfg%0d: got %0d expected %0d at %0t", name, cfg, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int PM    = g == 1 ? 2 : g == 2 ? 1 : 0;
        localparam int SB    = g == 3 ? 2 : 1;
        localparam int NB    = 9 + (PM != 0 ? 1 : 0) + SB;
        localparam int FRAME = NB * BAUD;
        localparam logic [15:0] MASK = 16'((1 << NB) - 1);

        logic        rst, valid, ready, done, txd;
        logic [7:0]  data;
        logic [15:0] exp_q[$];
        int          busy;
        bit          done_exp;
        int          nfr;

        uart_tx #(
            .CLK_FREQ   (1_000_000),
            .UART_BAUD  (100_000),
            .PARITY_MODE(PM),
            .STOP_BITS  (SB)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .tx_valid    (valid),
            .tx_data     (data),
            .tx_ready    (ready),
            .uart_tx_done(done),
            .uart_txd    (txd)
        );

        // line image of one frame, first bit on the line in bit 0; unused upper bits idle high
        function automatic logic [15:0] frame_bits(input logic [7:0] b);
            logic [15:0] f;
            int ones;
            ones = $countones(b);
            f = '1;
            f[0] = 1'b0;
            f[8:1] = b;
            if (PM == 1) f[9] = (ones % 2) == 0;
            if (PM == 2) f[9] = (ones % 2) == 1;
            return f;
        endfunction

        // reference model: a byte is taken whenever the line is free, then the block is busy for FRAME cycles
        initial begin
            busy = 0;
            done_exp = 0;
            forever begin
                @(posedge clk);
                done_exp = 0;
                if (rst) begin
                    if (busy > 0) void'(exp_q.pop_back());
                    busy = 0;
                end else if (busy > 0) begin
                    busy--;
                    done_exp = busy == 0;
                end else if (valid) begin
                    busy = FRAME;
                    exp_q.push_back(frame_bits(data));
                end
            end
        end

        initial begin
            bit cap, prev_rst, bad;
            bit samp[$];
            logic [15:0] f, got;
            cap = 0;
            prev_rst = 0;
            nfr = 0;
            forever begin
                @(negedge clk);
                if (prev_rst) chk("rst_state", int'({txd, ready, done}), 6, g);
                chk("ready", int'(ready), int'(busy == 0), g);
                chk("done", int'(done), int'(done_exp), g);
                if (done) begin
                    if (exp_q.size() == 0) chk("done_no_frame", 1, 0, g);
                    else begin
                        f = exp_q.pop_front();
                        got = '1;
                        bad = 0;
                        for (int b = 0; b < NB; b++) begin
                            for (int k = 0; k < BAUD; k++) begin
                                int i;
                                i = b * BAUD + k;
                                if (i >= samp.size()) bad = 1;
                                else begin
                                    if (k == 0) got[b] = samp[i];
                                    if (samp[i] != samp[b * BAUD]) bad = 1;
                                end
                            end
                        end
                        chk("frame_len", samp.size(), FRAME, g);
                        chk("frame_bits", int'(got & MASK), int'(f & MASK), g);
                        chk("bit_hold", int'(bad), 0, g);
                        nfr++;
                    end
                    cap = 0;
                    samp.delete();
                end else if (rst) begin
                    cap = 0;
                    samp.delete();
                end else if (cap || txd == 1'b0) begin
                    cap = 1;
                    samp.push_back(txd);
                end
                prev_rst = rst;
            end
        end

        initial begin
            int nrst;
            bit mid;
            nrst = 0;
            rst = 1'b1;
            valid = 1'b0;
            data = '0;
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            for (int c = 0; c < RUN; c++) begin
                @(posedge clk);
                #2;
                data = 8'($urandom);
                valid = ((c / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
                mid = nrst < 4 && (c % 700) > 300 && busy == FRAME - 45;
                if (mid) nrst++;
                rst = mid || (busy == 0 && valid && $urandom_range(0, 39) == 0);
            end
            @(posedge clk);
            #2;
            valid = 1'b0;
            rst = 1'b0;
            repeat (200) @(posedge clk);
            chk("drain", exp_q.size(), 0, g);
            chk("frames_seen", int'(nfr >= 10), 1, g);
            chk("mid_resets", int'(nrst >= 1), 1, g);
        end
    end

    initial begin
        repeat (RUN + 300) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
